// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU arbiter slice: bus widths,
// ALU control codes and the 1-bit port index used by the round-robin pointer.
package alu_pkg;
    localparam int WIDTH = 32;
    localparam int CTRLW = 4;

    localparam logic [CTRLW-1:0] ALU_ADD  = 4'd2;
    localparam logic [CTRLW-1:0] ALU_SRL  = 4'd4;
    localparam logic [CTRLW-1:0] ALU_SUB  = 4'd6;
    localparam logic [CTRLW-1:0] ALU_SLT  = 4'd7;
    localparam logic [CTRLW-1:0] ALU_ADDU = 4'd8;
    localparam logic [CTRLW-1:0] ALU_SUBU = 4'd9;
    localparam logic [CTRLW-1:0] ALU_XOR  = 4'd10;
    localparam logic [CTRLW-1:0] ALU_SLTU = 4'd11;
    localparam logic [CTRLW-1:0] ALU_NOR  = 4'd12;
    localparam logic [CTRLW-1:0] ALU_SRA  = 4'd13;
    localparam logic [CTRLW-1:0] ALU_LUI  = 4'd14;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_idx_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, their response ports and the shared-ALU
// connection. The master side is the parent; the slave side is the arbiter.
interface alu_arbiter_if;
    logic                        ReqValid0, ReqValid1;
    logic                        ReqReady0, ReqReady1;
    logic [alu_pkg::WIDTH-1:0]   ReqA0, ReqA1;
    logic [alu_pkg::WIDTH-1:0]   ReqB0, ReqB1;
    logic [alu_pkg::CTRLW-1:0]   ReqCtrl0, ReqCtrl1;
    logic                        RspValid0, RspValid1;
    logic                        RspReady0, RspReady1;
    logic [alu_pkg::WIDTH-1:0]   RspW0, RspW1;
    logic                        RspZero0, RspZero1;
    logic [alu_pkg::WIDTH-1:0]   AluBusA, AluBusB;
    logic [alu_pkg::CTRLW-1:0]   AluCtrl;
    logic [alu_pkg::WIDTH-1:0]   AluBusW;
    logic                        AluZero;

    modport master (
        output ReqValid0, ReqValid1, ReqA0, ReqA1, ReqB0, ReqB1, ReqCtrl0, ReqCtrl1,
        output RspReady0, RspReady1, AluBusW, AluZero,
        input  ReqReady0, ReqReady1, RspValid0, RspValid1, RspW0, RspW1,
        input  RspZero0, RspZero1, AluBusA, AluBusB, AluCtrl
    );

    modport slave (
        input  ReqValid0, ReqValid1, ReqA0, ReqA1, ReqB0, ReqB1, ReqCtrl0, ReqCtrl1,
        input  RspReady0, RspReady1, AluBusW, AluZero,
        output ReqReady0, ReqReady1, RspValid0, RspValid1, RspW0, RspW1,
        output RspZero0, RspZero1, AluBusA, AluBusB, AluCtrl
    );
endinterface

// File: rtl/alu_rsp_slot.sv
// One-entry response buffer: captures {Zero, W} on load, holds it until the
// consumer takes it, and reports whether a new result can be written this cycle.
module alu_rsp_slot
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             i_load,
    input  logic             i_rsp_ready,
    input  logic             i_zero,
    input  logic [WIDTH-1:0] i_w,
    output logic             o_rsp_valid,
    output logic [WIDTH-1:0] o_rsp_w,
    output logic             o_rsp_zero,
    output logic             o_can_load
);
    logic             r_valid;
    logic [WIDTH-1:0] r_w;
    logic             r_zero;

    // A full slot being drained this cycle can be refilled on the same edge.
    assign o_can_load  = ~r_valid | i_rsp_ready;
    assign o_rsp_valid = r_valid;
    assign o_rsp_w     = r_w;
    assign o_rsp_zero  = r_zero;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_valid <= 1'b0;
            r_w     <= '0;
            r_zero  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_w     <= i_w;
            r_zero  <= i_zero;
        end else if (r_valid && i_rsp_ready) begin
            // Data is left stale on a plain drain.
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// each port gets its result through a one-entry response slot.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic         CLK,
    input  logic         Reset,
    alu_arbiter_if.slave bus
);
    logic [1:0]       w_req_valid;
    logic [1:0]       w_rsp_ready;
    logic [1:0]       w_can_load;
    logic [1:0]       w_eligible;
    logic [1:0]       w_grant;
    logic [1:0]       w_rsp_valid;
    logic [1:0]       w_rsp_zero;
    logic [WIDTH-1:0] w_req_a  [2];
    logic [WIDTH-1:0] w_req_b  [2];
    logic [CTRLW-1:0] w_req_ctrl [2];
    logic [WIDTH-1:0] w_rsp_w  [2];
    logic             w_any;
    port_idx_t        w_winner;
    port_idx_t        r_last;

    assign w_req_valid   = {bus.ReqValid1, bus.ReqValid0};
    assign w_rsp_ready   = {bus.RspReady1, bus.RspReady0};
    assign w_req_a[0]    = bus.ReqA0;
    assign w_req_a[1]    = bus.ReqA1;
    assign w_req_b[0]    = bus.ReqB0;
    assign w_req_b[1]    = bus.ReqB1;
    assign w_req_ctrl[0] = bus.ReqCtrl0;
    assign w_req_ctrl[1] = bus.ReqCtrl1;

    assign w_eligible = w_req_valid & w_can_load & {2{~Reset}};
    assign w_any      = |w_eligible;

    always_comb begin
        w_winner = PORT0;
        if (&w_eligible) begin
            w_winner = (r_last == PORT0) ? PORT1 : PORT0;
        end else if (w_eligible[1]) begin
            w_winner = PORT1;
        end
        w_grant = {w_any && (w_winner == PORT1), w_any && (w_winner == PORT0)};
    end

    // Idle ALU inputs are forced to zero so nothing downstream toggles without a grant.
    always_comb begin
        bus.AluBusA = '0;
        bus.AluBusB = '0;
        bus.AluCtrl = '0;
        if (w_any) begin
            bus.AluBusA = (w_winner == PORT1) ? w_req_a[1]    : w_req_a[0];
            bus.AluBusB = (w_winner == PORT1) ? w_req_b[1]    : w_req_b[0];
            bus.AluCtrl = (w_winner == PORT1) ? w_req_ctrl[1] : w_req_ctrl[0];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_last <= PORT1;
        end else if (w_any) begin
            r_last <= w_winner;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            alu_rsp_slot u_slot (
                .clk         (CLK),
                .srst        (Reset),
                .i_load      (w_grant[gi]),
                .i_rsp_ready (w_rsp_ready[gi]),
                .i_zero      (bus.AluZero),
                .i_w         (bus.AluBusW),
                .o_rsp_valid (w_rsp_valid[gi]),
                .o_rsp_w     (w_rsp_w[gi]),
                .o_rsp_zero  (w_rsp_zero[gi]),
                .o_can_load  (w_can_load[gi])
            );
        end
    endgenerate

    assign bus.ReqReady0 = w_grant[0];
    assign bus.ReqReady1 = w_grant[1];
    assign bus.RspValid0 = w_rsp_valid[0];
    assign bus.RspValid1 = w_rsp_valid[1];
    assign bus.RspW0     = w_rsp_w[0];
    assign bus.RspW1     = w_rsp_w[1];
    assign bus.RspZero0  = w_rsp_zero[0];
    assign bus.RspZero1  = w_rsp_zero[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU stands in for the parent's shared ALU,
// followed by directed vectors and a randomized run against a reference model.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [3:0] c);
        logic [31:0] w;
        case (c)
            ALU_ADD, ALU_ADDU: w = a + b;
            ALU_SRL:           w = a >> b[4:0];
            ALU_SUB, ALU_SUBU: w = a - b;
            ALU_SLT:           w = {31'd0, $signed(a) < $signed(b)};
            ALU_XOR:           w = a ^ b;
            ALU_SLTU:          w = {31'd0, a < b};
            ALU_NOR:           w = ~(a | b);
            ALU_SRA:           w = $unsigned($signed(a) >>> b[4:0]);
            ALU_LUI:           w = {b[15:0], 16'h0000};
            default:           w = a & b;
        endcase
        return {(w == 32'd0), w};
    endfunction

    assign {bus.AluZero, bus.AluBusW} = alu_ref(bus.AluBusA, bus.AluBusB, bus.AluCtrl);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rv0, rv1, rr0, rr1;
        logic [31:0] a0, b0;
        logic [3:0]  c0;
        logic [31:0] a1, b1;
        logic [3:0]  c1;
        logic        e_rq0, e_rq1;
        logic [3:0]  e_ctrl;
        logic        e_v0, e_v1;
        logic [31:0] e_w0;
        logic        e_z0;
        logic [31:0] e_w1;
        logic        e_z1;
    } vec_t;

    task automatic drive(input logic r, input logic rv0, input logic rv1, input logic rr0,
                         input logic rr1, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] c0, input logic [31:0] a1, input logic [31:0] b1,
                         input logic [3:0] c1);
        rst = r;
        bus.ReqValid0 = rv0; bus.ReqValid1 = rv1;
        bus.RspReady0 = rr0; bus.RspReady1 = rr1;
        bus.ReqA0 = a0; bus.ReqB0 = b0; bus.ReqCtrl0 = c0;
        bus.ReqA1 = a1; bus.ReqB1 = b1; bus.ReqCtrl1 = c1;
    endtask

    // Called one time unit after a rising edge; returns one time unit after the next.
    task automatic apply_vec(input vec_t v, input string tag);
        logic [31:0] e_a, e_b;
        drive(v.rst, v.rv0, v.rv1, v.rr0, v.rr1, v.a0, v.b0, v.c0, v.a1, v.b1, v.c1);
        e_a = v.e_rq0 ? v.a0 : (v.e_rq1 ? v.a1 : 32'd0);
        e_b = v.e_rq0 ? v.b0 : (v.e_rq1 ? v.b1 : 32'd0);
        #1;
        check({tag, ".ReqReady0"}, bus.ReqReady0, v.e_rq0);
        check({tag, ".ReqReady1"}, bus.ReqReady1, v.e_rq1);
        check({tag, ".AluCtrl"},   bus.AluCtrl,   v.e_ctrl);
        check({tag, ".AluBusA"},   bus.AluBusA,   e_a);
        check({tag, ".AluBusB"},   bus.AluBusB,   e_b);
        @(posedge clk);
        #1;
        check({tag, ".RspValid0"}, bus.RspValid0, v.e_v0);
        check({tag, ".RspValid1"}, bus.RspValid1, v.e_v1);
        if (v.e_v0 || v.rst) begin
            check({tag, ".RspW0"},    bus.RspW0,    v.e_w0);
            check({tag, ".RspZero0"}, bus.RspZero0, v.e_z0);
        end
        if (v.e_v1 || v.rst) begin
            check({tag, ".RspW1"},    bus.RspW1,    v.e_w1);
            check({tag, ".RspZero1"}, bus.RspZero1, v.e_z1);
        end
        $display("vec %s: rq=%b%b valid=%b%b w0=%h w1=%h", tag, v.e_rq1, v.e_rq0,
                 bus.RspValid1, bus.RspValid0, bus.RspW0, bus.RspW1);
    endtask

    vec_t vecs[13];

    // Reference model state: one result slot per port plus the last-granted port.
    logic        m_valid [2];
    logic [31:0] m_w     [2];
    logic        m_z     [2];
    int          m_last;

    initial begin
        // rst, rv0 rv1 rr0 rr1, a0 b0 c0, a1 b1 c1, rq0 rq1 ctrl, v0 v1, w0 z0, w1 z1
        vecs[0]  = '{0, 1,0,0,0, 32'h11, 32'h2, ALU_ADD, 0, 0, 4'd0,  1,0, 4'd2,  1,0, 32'h13, 0, 0, 0};
        vecs[1]  = '{0, 0,0,1,0, 0, 0, 4'd0, 0, 0, 4'd0,              0,0, 4'd0,  0,0, 0, 0, 0, 0};
        vecs[2]  = '{1, 1,1,0,0, 32'h11, 32'h2, ALU_ADD, 32'h5, 32'h6, ALU_ADD, 0,0, 4'd0, 0,0, 0, 0, 0, 0};
        vecs[3]  = '{0, 1,1,1,1, 32'h1, 32'h1, ALU_SUBU, 32'hF0F0F0F0, 32'h0000FFFF, ALU_XOR,
                     1,0, 4'd9,  1,0, 32'h0, 1, 0, 0};
        // True XOR of the two operands.
        vecs[4]  = '{0, 0,1,1,1, 32'h1, 32'h1, ALU_SUBU, 32'hF0F0F0F0, 32'h0000FFFF, ALU_XOR,
                     0,1, 4'd10, 0,1, 0, 0, 32'hF0F00F0F, 0};
        vecs[5]  = '{0, 0,0,1,1, 0, 0, 4'd0, 0, 0, 4'd0,              0,0, 4'd0,  0,0, 0, 0, 0, 0};
        for (int i = 6; i < 12; i++) begin
            if ((i % 2) == 0)
                vecs[i] = '{0, 1,1,1,1, 32'h10, 32'h1, ALU_ADD, 32'h30, 32'h10, ALU_SUB,
                            1,0, 4'd2, 1,0, 32'h11, 0, 0, 0};
            else
                vecs[i] = '{0, 1,1,1,1, 32'h10, 32'h1, ALU_ADD, 32'h30, 32'h10, ALU_SUB,
                            0,1, 4'd6, 0,1, 0, 0, 32'h20, 0};
        end
        vecs[12] = '{0, 0,0,1,1, 0, 0, 4'd0, 0, 0, 4'd0,              0,0, 4'd0,  0,0, 0, 0, 0, 0};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset.RspValid0", bus.RspValid0, 1'b0);
        check("reset.RspValid1", bus.RspValid1, 1'b0);
        check("reset.RspW0",     bus.RspW0,     32'd0);
        check("reset.RspW1",     bus.RspW1,     32'd0);
        check("reset.RspZero0",  bus.RspZero0,  1'b0);
        check("reset.RspZero1",  bus.RspZero1,  1'b0);

        for (int i = 0; i < 13; i++) apply_vec(vecs[i], $sformatf("tbl%0d", i));

        // Backpressure: port 0 held full, port 1 takes every grant, then drain-and-refill.
        apply_vec('{0, 1,0,0,1, 32'h5, 32'h5, ALU_ADD, 0, 0, 4'd0, 1,0, 4'd2, 1,0, 32'hA, 0, 0, 0}, "bp0");
        for (int i = 1; i < 4; i++)
            apply_vec('{0, 1,1,0,1, 32'h7, 32'h7, ALU_ADD, 32'h1, 32'h2, ALU_ADD,
                        0,1, 4'd2, 1,1, 32'hA, 0, 32'h3, 0}, $sformatf("bp%0d", i));
        apply_vec('{0, 1,1,1,1, 32'h7, 32'h7, ALU_ADD, 32'h1, 32'h2, ALU_ADD,
                    1,0, 4'd2, 1,0, 32'hE, 0, 0, 0}, "bp4");
        apply_vec('{0, 0,0,1,1, 0, 0, 4'd0, 0, 0, 4'd0, 0,0, 4'd0, 0,0, 0, 0, 0, 0}, "bp5");

        // Reset mid-operation with both slots full and the pointer on port 0.
        apply_vec('{0, 0,1,0,0, 0, 0, 4'd0, 32'h3, 32'h4, ALU_ADD, 0,1, 4'd2, 0,1, 0, 0, 32'h7, 0}, "rs0");
        apply_vec('{0, 1,0,0,0, 32'h5, 32'h5, ALU_ADD, 0, 0, 4'd0, 1,0, 4'd2, 1,1, 32'hA, 0, 32'h7, 0}, "rs1");
        apply_vec('{1, 1,1,0,0, 32'h5, 32'h5, ALU_ADD, 32'h3, 32'h4, ALU_ADD,
                    0,0, 4'd0, 0,0, 0, 0, 0, 0}, "rs2");
        apply_vec('{0, 1,1,1,1, 32'h2, 32'h2, ALU_ADD, 32'h3, 32'h4, ALU_ADD,
                    1,0, 4'd2, 1,0, 32'h4, 0, 0, 0}, "rs3");
        apply_vec('{0, 0,0,1,1, 0, 0, 4'd0, 0, 0, 4'd0, 0,0, 4'd0, 0,0, 0, 0, 0, 0}, "rs4");

        // Operand pass-through on port 1.
        apply_vec('{0, 0,1,0,0, 0, 0, 4'd0, 32'hFFFF1234, 32'h6, ALU_SRA,
                    0,1, 4'd13, 0,1, 0, 0, 32'hFFFFFC48, 0}, "pt0");
        apply_vec('{0, 0,0,1,1, 0, 0, 4'd0, 0, 0, 4'd0, 0,0, 4'd0, 0,0, 0, 0, 0, 0}, "pt1");

        // Randomized run; the first cycle is a reset so the model starts in step.
        m_last = 1;
        for (int p = 0; p < 2; p++) begin
            m_valid[p] = 1'b0; m_w[p] = '0; m_z[p] = 1'b0;
        end
        for (int n = 0; n < 250; n++) begin
            logic        r;
            logic        rv [2];
            logic        rr [2];
            logic [31:0] a  [2];
            logic [31:0] b  [2];
            logic [3:0]  c  [2];
            logic        want [2];
            int          winner;
            logic [31:0] e_a, e_b;
            logic [3:0]  e_c;
            logic [32:0] res;
            r = (n == 0) || ($urandom_range(0, 29) == 0);
            for (int p = 0; p < 2; p++) begin
                rv[p] = ($urandom_range(0, 3) != 0);
                rr[p] = ($urandom_range(0, 2) != 0);
                a[p]  = $urandom;
                b[p]  = ($urandom_range(0, 3) == 0) ? a[p] : $urandom;
                c[p]  = 4'($urandom_range(0, 15));
            end
            drive(r, rv[0], rv[1], rr[0], rr[1], a[0], b[0], c[0], a[1], b[1], c[1]);
            for (int p = 0; p < 2; p++) want[p] = rv[p] && !r && (!m_valid[p] || rr[p]);
            if (want[0] && want[1]) winner = 1 - m_last;
            else if (want[0])       winner = 0;
            else if (want[1])       winner = 1;
            else                    winner = -1;
            e_a = (winner >= 0) ? a[winner] : 32'd0;
            e_b = (winner >= 0) ? b[winner] : 32'd0;
            e_c = (winner >= 0) ? c[winner] : 4'd0;
            res = alu_ref(e_a, e_b, e_c);
            #1;
            check("rnd.ReqReady0", bus.ReqReady0, winner == 0);
            check("rnd.ReqReady1", bus.ReqReady1, winner == 1);
            check("rnd.AluBusA",   bus.AluBusA,   e_a);
            check("rnd.AluBusB",   bus.AluBusB,   e_b);
            check("rnd.AluCtrl",   bus.AluCtrl,   e_c);
            @(posedge clk);
            #1;
            if (r) begin
                m_last = 1;
                for (int p = 0; p < 2; p++) begin
                    m_valid[p] = 1'b0; m_w[p] = '0; m_z[p] = 1'b0;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (winner == p) begin
                        m_valid[p] = 1'b1; m_z[p] = res[32]; m_w[p] = res[31:0];
                    end else if (m_valid[p] && rr[p]) begin
                        m_valid[p] = 1'b0;
                    end
                end
                if (winner >= 0) m_last = winner;
            end
            check("rnd.RspValid0", bus.RspValid0, m_valid[0]);
            check("rnd.RspValid1", bus.RspValid1, m_valid[1]);
            check("rnd.RspW0",     bus.RspW0,     m_w[0]);
            check("rnd.RspW1",     bus.RspW1,     m_w[1]);
            check("rnd.RspZero0",  bus.RspZero0,  m_z[0]);
            check("rnd.RspZero1",  bus.RspZero1,  m_z[1]);
            $display("rnd %0d: rst=%b grant=%0d valid=%b%b", n, r, winner,
                     bus.RspValid1, bus.RspValid0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
